sipo_4bit_frame_rx: RTL

//  - Serial-in/parallel-out receiver for the LSB-first stream produced by our PISO shift register.
//  - frame_sync marks bit 0 of each word.
//  - After N data bits are received, the word is registered onto a valid/ready parallel output

---
 rtl/sipo_4bit_frame_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sipo_4bit_frame_rx.sv
// sipo_4bit_frame_rx: LSB-first serial-to-parallel receiver aligned by frame_sync, feeding a
// one-word valid/ready output buffer. Define PARITY_CHECK_EN to expect a trailing even-parity bit.
module sipo_4bit_frame_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         frame_sync,
  output logic [N-1:0] P,
  output logic         p_valid,
  input  logic         p_ready,
  output logic         overrun,
  output logic         frame_err,
  output logic         parity_err
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    HUNT,
    SHIFT
`ifdef PARITY_CHECK_EN
    , PARITY
`endif
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [N-2:0]  r_sreg, w_sreg_next;
  logic [N-1:0]  w_word;
  logic [N-1:0]  w_out_word;
  logic          w_complete;
  logic          w_frame_err;

  logic [N-1:0]  r_p;
  logic          r_p_valid;
  logic          r_overrun;
  logic          r_frame_err;

`ifdef PARITY_CHECK_EN
  logic [N-1:0]  r_word, w_word_next;
  logic          w_par_err;
  logic          r_parity_err;
`endif

  // The bits seen so far sit in r_sreg with bit 0 at the bottom; the incoming bit goes on top.
  assign w_word = {serial_in, r_sreg};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_sreg  <= '0;
`ifdef PARITY_CHECK_EN
      r_word  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sreg  <= w_sreg_next;
`ifdef PARITY_CHECK_EN
      r_word  <= w_word_next;
`endif
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sreg_next  = r_sreg;
    w_complete   = 1'b0;
    w_frame_err  = 1'b0;
    w_out_word   = w_word;
`ifdef PARITY_CHECK_EN
    w_word_next  = r_word;
    w_par_err    = 1'b0;
`endif
    if (bit_valid) begin
      w_sreg_next = w_word[N-1:1];
      if (frame_sync) begin
        // A sync bit always starts a new word; mid-word it also discards the partial one.
        w_frame_err  = (r_state != HUNT);
        w_cnt_next   = CW'(1);
        w_state_next = SHIFT;
      end else begin
        case (r_state)
          SHIFT: begin
            if (r_cnt == LAST) begin
              w_cnt_next = '0;
`ifdef PARITY_CHECK_EN
              w_word_next  = w_word;
              w_state_next = PARITY;
`else
              w_complete   = 1'b1;
              w_state_next = HUNT;
`endif
            end else begin
              w_cnt_next = r_cnt + CW'(1);
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            w_complete   = 1'b1;
            w_out_word   = r_word;
            w_par_err    = ^{r_word, serial_in};
            w_state_next = HUNT;
          end
`endif
          default: w_state_next = HUNT;
        endcase
      end
    end
  end

  // Output buffer: a completed word is accepted only if the slot is free or emptying this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p          <= '0;
      r_p_valid    <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= w_frame_err;
      if (w_complete) begin
        if (!r_p_valid || p_ready) begin
          r_p          <= w_out_word;
          r_p_valid    <= 1'b1;
`ifdef PARITY_CHECK_EN
          r_parity_err <= w_par_err;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_p_valid && p_ready) begin
        r_p_valid    <= 1'b0;
`ifdef PARITY_CHECK_EN
        r_parity_err <= 1'b0;
`endif
      end
    end
  end

  assign P         = r_p;
  assign p_valid   = r_p_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
`ifdef PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
